tick_rate_ctrl: RTL and testbench

- Generates the game's timing ticks from the system clock: a one-cycle clock-enable pulse every div_cur cycles, with a programmable divisor.
- Sequences start, pause and stop of the tick stream, and accepts divisor updates (explicit load or "speed-up" step) through a request/acknowledge handshake.
- Updates are applied only at period boundaries, so a tick period is never truncated.
- Sits between the game FSM (requester) and all tick-driven logic (LED/score/timeout counters).

---
 rtl/tick_rate_ctrl_pkg.sv | 16 +
 rtl/tick_rate_ctrl_period_cnt.sv | 29 ++
 rtl/tick_rate_ctrl.sv | 154 +++++++++++++++
 tb/tb_tick_rate_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_ctrl_pkg.sv
// Shared definitions for the tick rate controller: FSM state encoding and
// default divisor limits used by tick_rate_ctrl and its testbench.
package tick_rate_ctrl_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE = 2'd0,
        TRC_RUN  = 2'd1,
        TRC_HOLD = 2'd2
    } trc_state_t;

    localparam int TRC_CNT_W   = 26;
    localparam int TRC_DEF_DIV = 50_000_000;
    localparam int TRC_MIN_DIV = 2;
    localparam int TRC_SPD_SH  = 3;

endpackage

// File: rtl/tick_rate_ctrl_period_cnt.sv
// Down-counting period counter: clear, load, enable-decrement, zero detect.
module tick_period_cnt #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Counter register: clear beats load beats decrement.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tick_rate_ctrl.sv
// Game tick generator: one-cycle tick every div_cur cycles with start/pause/
// stop sequencing and divisor updates applied only at period boundaries.
// Optional build macro TICK_SQUARE_OUT_EN adds sq_out, a square wave that
// toggles on every tick (period 2*div_cur).
module tick_rate_ctrl
    import tick_rate_ctrl_pkg::*;
#(
    parameter int CNT_W   = TRC_CNT_W,
    parameter int DEF_DIV = TRC_DEF_DIV,
    parameter int MIN_DIV = TRC_MIN_DIV,
    parameter int SPD_SH  = TRC_SPD_SH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    input  logic             speedup,
    output logic             div_ack,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] div_cur,
    output logic [15:0]      tick_cnt
`ifdef TICK_SQUARE_OUT_EN
    ,
    output logic             sq_out
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);

    trc_state_t       state, state_nxt;
    logic             pending;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] req_raw;
    logic [CNT_W-1:0] req_val;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             start_go;
    logic             stop_go;
    logic             reload;
    logic             apply;
    logic             cnt_load;
    logic             cnt_en;

    // Requested divisor: explicit load wins over a speed-up step, both clamped to MIN_DIV.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        req_raw = div_cur - (div_cur >> SPD_SH);
        if (div_req) begin
            req_raw = div_val;
        end
        req_val = (req_raw < DIV_MIN) ? DIV_MIN : req_raw;
    end

    // Control decode. The counter freezes as soon as pause is seen, except on
    // the reload cycle, where the tick and reload still go through.
    always_comb begin
        stop_go  = stop && (state != TRC_IDLE);
        start_go = start && !stop && (state == TRC_IDLE);
        reload   = (state == TRC_RUN) && !stop && cnt_zero;
        apply    = pending && ((state == TRC_IDLE) || reload);
        div_nxt  = apply ? pend_val : div_cur;
        cnt_load = start_go || reload;
        cnt_en   = (state == TRC_RUN) && !stop && !pause && !cnt_zero;
    end

    tick_period_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (stop_go),
        .load    (cnt_load),
        .load_val(div_nxt - CNT_W'(1)),
        .en      (cnt_en),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TRC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop beats start and pause.
    always_comb begin
        state_nxt = state;
        case (state)
            TRC_IDLE: if (start_go) state_nxt = TRC_RUN;
            TRC_RUN: begin
                if (stop)       state_nxt = TRC_IDLE;
                else if (pause) state_nxt = TRC_HOLD;
            end
            TRC_HOLD: begin
                if (stop)        state_nxt = TRC_IDLE;
                else if (!pause) state_nxt = TRC_RUN;
            end
            default: state_nxt = TRC_IDLE;
        endcase
    end

    // Tick, tick count, divisor and pending-update registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            tick_cnt <= '0;
            div_cur  <= DIV_RST;
            pending  <= 1'b0;
            pend_val <= DIV_RST;
        end else begin
            tick    <= reload;
            div_ack <= apply;
            if (apply) begin
                div_cur <= pend_val;
            end
            // A request landing on the apply cycle re-arms pending for the next boundary.
            if (div_req || speedup) begin
                pending  <= 1'b1;
                pend_val <= req_val;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (start_go) begin
                tick_cnt <= '0;
            end else if (reload) begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    assign running = (state != TRC_IDLE);

`ifdef TICK_SQUARE_OUT_EN
    // Square output toggles with each tick and holds naturally while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_out <= 1'b0;
        end else if (reload) begin
            sq_out <= !sq_out;
        end
    end
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed testbench for tick_rate_ctrl, built with DEF_DIV=4.
// Edge numbering: edge 0 is the edge that samples start; outputs are
// checked 1 ns after each edge.
module tb_tick_rate_ctrl;

    localparam int CNT_W = 26;

    logic             clk = 1'b0;
    logic             rst, start, stop, pause, div_req, speedup;
    logic [CNT_W-1:0] div_val;
    logic             div_ack, tick, running;
    logic [CNT_W-1:0] div_cur;
    logic [15:0]      tick_cnt;
`ifdef TICK_SQUARE_OUT_EN
    logic             sq_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tick_rate_ctrl #(
        .CNT_W  (CNT_W),
        .DEF_DIV(4),
        .MIN_DIV(2),
        .SPD_SH (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .div_req (div_req),
        .div_val (div_val),
        .speedup (speedup),
        .div_ack (div_ack),
        .tick    (tick),
        .running (running),
        .div_cur (div_cur),
`ifdef TICK_SQUARE_OUT_EN
        .sq_out  (sq_out),
`endif
        .tick_cnt(tick_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        div_req = 1'b0; speedup = 1'b0; div_val = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", div_ack); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got=%b exp=0", running); end
        n_cmp++; if (tick_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_tick_cnt got=%0d exp=0", tick_cnt); end
        n_cmp++; if (div_cur !== CNT_W'(4)) begin n_bad++; $display("FAIL reset_div_cur got=%0d exp=4", div_cur); end
    endtask

    task automatic test_basic();
        logic exp_tick;
        apply_reset();
        do_start();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL basic_running got=%b exp=1", running); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL basic_tick0 got=%b exp=0", tick); end
        for (int e = 1; e <= 16; e++) begin
            cyc();
            exp_tick = (e % 4 == 0);
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL basic_tick e=%0d got=%b exp=%b", e, tick, exp_tick); end
            n_cmp++; if (tick_cnt !== 16'(e / 4)) begin n_bad++; $display("FAIL basic_tick_cnt e=%0d got=%0d exp=%0d", e, tick_cnt, e / 4); end
`ifdef TICK_SQUARE_OUT_EN
            n_cmp++; if (sq_out !== 1'((e / 4) % 2)) begin n_bad++; $display("FAIL sq_out e=%0d got=%b exp=%b", e, sq_out, 1'((e / 4) % 2)); end
`endif
        end
    endtask

    task automatic test_div_load();
        logic exp_tick, exp_ack;
        logic [CNT_W-1:0] exp_div;
        apply_reset();
        do_start();
        for (int e = 1; e <= 20; e++) begin
            if (e == 2) begin div_req = 1'b1; div_val = CNT_W'(7); end
            cyc();
            div_req = 1'b0;
            exp_tick = (e == 4) || (e == 11) || (e == 18);
            exp_ack  = (e == 4);
            exp_div  = (e >= 4) ? CNT_W'(7) : CNT_W'(4);
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL load_tick e=%0d got=%b exp=%b", e, tick, exp_tick); end
            n_cmp++; if (div_ack !== exp_ack) begin n_bad++; $display("FAIL load_ack e=%0d got=%b exp=%b", e, div_ack, exp_ack); end
            n_cmp++; if (div_cur !== exp_div) begin n_bad++; $display("FAIL load_div e=%0d got=%0d exp=%0d", e, div_cur, exp_div); end
        end
        n_cmp++; if (tick_cnt !== 16'd3) begin n_bad++; $display("FAIL load_tick_cnt got=%0d exp=3", tick_cnt); end
    endtask

    task automatic test_speedup();
        logic exp_tick, exp_ack;
        logic [CNT_W-1:0] exp_div;
        apply_reset();
        div_req = 1'b1; div_val = CNT_W'(16);
        cyc();
        div_req = 1'b0;
        cyc();
        n_cmp++; if (div_cur !== CNT_W'(16)) begin n_bad++; $display("FAIL idle_load_div got=%0d exp=16", div_cur); end
        n_cmp++; if (div_ack !== 1'b1) begin n_bad++; $display("FAIL idle_load_ack got=%b exp=1", div_ack); end
        cyc();
        n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL idle_ack_pulse got=%b exp=0", div_ack); end
        do_start();
        for (int e = 1; e <= 30; e++) begin
            if (e == 3) speedup = 1'b1;
            cyc();
            speedup = 1'b0;
            exp_tick = (e == 16) || (e == 30);
            exp_ack  = (e == 16);
            exp_div  = (e >= 16) ? CNT_W'(14) : CNT_W'(16);
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL spd_tick e=%0d got=%b exp=%b", e, tick, exp_tick); end
            n_cmp++; if (div_ack !== exp_ack) begin n_bad++; $display("FAIL spd_ack e=%0d got=%b exp=%b", e, div_ack, exp_ack); end
            n_cmp++; if (div_cur !== exp_div) begin n_bad++; $display("FAIL spd_div e=%0d got=%0d exp=%0d", e, div_cur, exp_div); end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL spd_stop_running got=%b exp=0", running); end
        div_req = 1'b1; div_val = CNT_W'(0);
        cyc();
        div_req = 1'b0;
        cyc();
        n_cmp++; if (div_cur !== CNT_W'(2)) begin n_bad++; $display("FAIL clamp_zero got=%0d exp=2", div_cur); end
        for (int i = 0; i < 3; i++) begin
            speedup = 1'b1;
            cyc();
            speedup = 1'b0;
            cyc();
            n_cmp++; if (div_cur !== CNT_W'(2)) begin n_bad++; $display("FAIL spd_floor i=%0d got=%0d exp=2", i, div_cur); end
            n_cmp++; if (div_ack !== 1'b1) begin n_bad++; $display("FAIL spd_floor_ack i=%0d got=%b exp=1", i, div_ack); end
        end
        div_req = 1'b1; div_val = CNT_W'(1);
        cyc();
        div_req = 1'b0;
        cyc();
        n_cmp++; if (div_cur !== CNT_W'(2)) begin n_bad++; $display("FAIL clamp_one got=%0d exp=2", div_cur); end
        do_start();
        for (int e = 1; e <= 6; e++) begin
            cyc();
            n_cmp++; if (tick !== (e % 2 == 0)) begin n_bad++; $display("FAIL min_div_tick e=%0d got=%b exp=%b", e, tick, (e % 2 == 0)); end
        end
    endtask

    task automatic test_pause();
        logic exp_tick;
        apply_reset();
        do_start();
        for (int e = 1; e <= 34; e++) begin
            pause = ((e >= 6) && (e <= 15)) || ((e >= 27) && (e <= 29));
            cyc();
            exp_tick = (e == 4) || (e == 19) || (e == 23) || (e == 27) || (e == 34);
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL pause_tick e=%0d got=%b exp=%b", e, tick, exp_tick); end
            n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL pause_running e=%0d got=%b exp=1", e, running); end
        end
        pause = 1'b0;
        n_cmp++; if (tick_cnt !== 16'd5) begin n_bad++; $display("FAIL pause_tick_cnt got=%0d exp=5", tick_cnt); end
    endtask

    task automatic test_stop();
        apply_reset();
        do_start();
        for (int e = 1; e <= 3; e++) cyc();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stop_tick got=%b exp=0", tick); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running got=%b exp=0", running); end
        n_cmp++; if (tick_cnt !== 16'd0) begin n_bad++; $display("FAIL stop_tick_cnt got=%0d exp=0", tick_cnt); end
        for (int e = 0; e < 6; e++) begin
            cyc();
            n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL idle_tick e=%0d got=%b exp=0", e, tick); end
        end
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL idle_start_stop got=%b exp=0", running); end
        do_start();
        for (int e = 1; e <= 4; e++) begin
            cyc();
            n_cmp++; if (tick !== (e == 4)) begin n_bad++; $display("FAIL restart_tick e=%0d got=%b exp=%b", e, tick, (e == 4)); end
        end
    endtask

    task automatic test_reset_pending();
        apply_reset();
        do_start();
        cyc();
        div_req = 1'b1; div_val = CNT_W'(7);
        cyc();
        div_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (div_cur !== CNT_W'(4)) begin n_bad++; $display("FAIL rstpend_div got=%0d exp=4", div_cur); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rstpend_running got=%b exp=0", running); end
        for (int e = 0; e < 3; e++) begin
            cyc();
            n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL rstpend_ack e=%0d got=%b exp=0", e, div_ack); end
            n_cmp++; if (div_cur !== CNT_W'(4)) begin n_bad++; $display("FAIL rstpend_div_hold e=%0d got=%0d exp=4", e, div_cur); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_tick, exp_ack;
        logic [CNT_W-1:0] exp_div;
        apply_reset();
        do_start();
        for (int e = 1; e <= 22; e++) begin
            case (e)
                1:  begin div_req = 1'b1; div_val = CNT_W'(9); end
                2:  begin div_req = 1'b1; div_val = CNT_W'(5); end
                3:  begin div_req = 1'b1; speedup = 1'b1; div_val = CNT_W'(6); end
                10: begin div_req = 1'b1; div_val = CNT_W'(3); end
                default: ;
            endcase
            cyc();
            div_req = 1'b0; speedup = 1'b0;
            exp_tick = (e == 4) || (e == 10) || (e == 16) || (e == 19) || (e == 22);
            exp_ack  = (e == 4) || (e == 16);
            exp_div  = (e < 4) ? CNT_W'(4) : ((e < 16) ? CNT_W'(6) : CNT_W'(3));
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL b2b_tick e=%0d got=%b exp=%b", e, tick, exp_tick); end
            n_cmp++; if (div_ack !== exp_ack) begin n_bad++; $display("FAIL b2b_ack e=%0d got=%b exp=%b", e, div_ack, exp_ack); end
            n_cmp++; if (div_cur !== exp_div) begin n_bad++; $display("FAIL b2b_div e=%0d got=%0d exp=%0d", e, div_cur, exp_div); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_div_load();
        test_speedup();
        test_pause();
        test_stop();
        test_reset_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
